// File: rtl/rvfi_cover_monitor.sv
// Coverage-goal monitor for RVFI retire traffic: counts qualified retire events
// while armed and reports whether the goal thresholds are met before a cycle budget expires.
module rvfi_cover_monitor #(
    parameter int NRET    = 1,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 20
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 arm,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [32*NRET-1:0]   rvfi_insn,
    input  logic [4*NRET-1:0]    rvfi_mem_rmask,
    input  logic [4*NRET-1:0]    rvfi_mem_wmask,
    input  logic                 instr_req_valid,
    input  logic                 instr_req_ready,
    input  logic [CNT_W-1:0]     thr_rd,
    input  logic [CNT_W-1:0]     thr_wr,
    input  logic [CNT_W-1:0]     thr_long,
    input  logic [CNT_W-1:0]     thr_compr,
    output logic [CNT_W-1:0]     cnt_rd,
    output logic [CNT_W-1:0]     cnt_wr,
    output logic [CNT_W-1:0]     cnt_long,
    output logic [CNT_W-1:0]     cnt_compr,
    output logic [CNT_W-1:0]     cnt_ireq,
    output logic [CNT_W-1:0]     cnt_cycles,
    output logic [1:0]           state,
    output logic                 goal_met,
    output logic                 timed_out
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MET     = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [32:0] TIMEOUT_L = 33'(TIMEOUT);

    state_t            state_r;
    logic [NRET-1:0]   ret_s;
    logic [2:0]        n_rd_s;
    logic [2:0]        n_wr_s;
    logic [2:0]        n_long_s;
    logic [2:0]        n_compr_s;
    logic [2:0]        n_ireq_s;
    logic              goal_s;
    logic              tmo_s;
    logic              insn_unused_s;

    // Adds a small per-cycle event count, clamping at the counter maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        if (sum[CNT_W]) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Only the opcode size bits of each instruction word matter here.
    assign insn_unused_s = ^rvfi_insn;

    assign ret_s     = rvfi_valid & ~rvfi_trap;
    assign n_ireq_s  = {2'b00, instr_req_valid & instr_req_ready};
    assign goal_s    = (cnt_rd >= thr_rd) && (cnt_wr >= thr_wr) &&
                       (cnt_long >= thr_long) && (cnt_compr >= thr_compr);
    assign tmo_s     = (TIMEOUT_L != 33'd0) && (33'(cnt_cycles) >= TIMEOUT_L);

    // Per-cycle event population counts across all retire channels.
    always_comb begin
        n_rd_s    = 3'd0;
        n_wr_s    = 3'd0;
        n_long_s  = 3'd0;
        n_compr_s = 3'd0;
        for (int k = 0; k < NRET; k++) begin
            n_rd_s    = n_rd_s    + {2'b00, ret_s[k] & (|rvfi_mem_rmask[4*k +: 4])};
            n_wr_s    = n_wr_s    + {2'b00, ret_s[k] & (|rvfi_mem_wmask[4*k +: 4])};
            n_long_s  = n_long_s  + {2'b00, ret_s[k] & (&rvfi_insn[32*k +: 2])};
            n_compr_s = n_compr_s + {2'b00, ret_s[k] & ~(&rvfi_insn[32*k +: 2])};
        end
    end

    // Goal FSM and event counters; clear returns everything to IDLE with zero counts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            cnt_rd     <= '0;
            cnt_wr     <= '0;
            cnt_long   <= '0;
            cnt_compr  <= '0;
            cnt_ireq   <= '0;
            cnt_cycles <= '0;
        end else if (clear) begin
            state_r    <= ST_IDLE;
            cnt_rd     <= '0;
            cnt_wr     <= '0;
            cnt_long   <= '0;
            cnt_compr  <= '0;
            cnt_ireq   <= '0;
            cnt_cycles <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    cnt_rd     <= sat_add(cnt_rd, n_rd_s);
                    cnt_wr     <= sat_add(cnt_wr, n_wr_s);
                    cnt_long   <= sat_add(cnt_long, n_long_s);
                    cnt_compr  <= sat_add(cnt_compr, n_compr_s);
                    cnt_ireq   <= sat_add(cnt_ireq, n_ireq_s);
                    cnt_cycles <= sat_add(cnt_cycles, 3'd1);
                    // Goal is checked first so it wins a tie with the budget expiring.
                    if (goal_s) begin
                        state_r <= ST_MET;
                    end else if (tmo_s) begin
                        state_r <= ST_TIMEOUT;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_MET:     state_r <= ST_MET;
                ST_TIMEOUT: state_r <= ST_TIMEOUT;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    assign state     = state_r;
    assign goal_met  = (state_r == ST_MET);
    assign timed_out = (state_r == ST_TIMEOUT);

endmodule

// File: tb/tb_rvfi_cover_monitor.sv
// Self-checking bench: directed goal/timeout/saturation scenarios plus randomized traffic
// checked against a cycle-level reference model on a 1-channel and a 2-channel instance.
module tb_rvfi_cover_monitor;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clear = 1'b0;
    logic arm = 1'b0;
    logic ireq_v = 1'b0;
    logic ireq_r = 1'b0;

    always #5 clk = ~clk;

    // instance A: NRET=1, CNT_W=8, TIMEOUT=20
    logic        va, ta;
    logic [31:0] insn_a;
    logic [3:0]  rm_a, wm_a;
    logic [7:0]  thr_rd_a, thr_wr_a, thr_long_a, thr_compr_a;
    logic [7:0]  cnt_rd_a, cnt_wr_a, cnt_long_a, cnt_compr_a, cnt_ireq_a, cnt_cycles_a;
    logic [1:0]  st_a;
    logic        gm_a, to_a;

    // instance B: NRET=2, CNT_W=4, TIMEOUT=20
    logic [1:0]  vb, trb;
    logic [63:0] insn_b;
    logic [7:0]  rm_b, wm_b;
    logic [3:0]  thr_rd_b, thr_wr_b, thr_long_b, thr_compr_b;
    logic [3:0]  cnt_rd_b, cnt_wr_b, cnt_long_b, cnt_compr_b, cnt_ireq_b, cnt_cycles_b;
    logic [1:0]  st_b;
    logic        gm_b, to_b;

    rvfi_cover_monitor #(.NRET(1), .CNT_W(8), .TIMEOUT(20)) u_a (
        .clk(clk), .resetn(resetn), .clear(clear), .arm(arm),
        .rvfi_valid(va), .rvfi_trap(ta), .rvfi_insn(insn_a),
        .rvfi_mem_rmask(rm_a), .rvfi_mem_wmask(wm_a),
        .instr_req_valid(ireq_v), .instr_req_ready(ireq_r),
        .thr_rd(thr_rd_a), .thr_wr(thr_wr_a), .thr_long(thr_long_a), .thr_compr(thr_compr_a),
        .cnt_rd(cnt_rd_a), .cnt_wr(cnt_wr_a), .cnt_long(cnt_long_a), .cnt_compr(cnt_compr_a),
        .cnt_ireq(cnt_ireq_a), .cnt_cycles(cnt_cycles_a),
        .state(st_a), .goal_met(gm_a), .timed_out(to_a)
    );

    rvfi_cover_monitor #(.NRET(2), .CNT_W(4), .TIMEOUT(20)) u_b (
        .clk(clk), .resetn(resetn), .clear(clear), .arm(arm),
        .rvfi_valid(vb), .rvfi_trap(trb), .rvfi_insn(insn_b),
        .rvfi_mem_rmask(rm_b), .rvfi_mem_wmask(wm_b),
        .instr_req_valid(ireq_v), .instr_req_ready(ireq_r),
        .thr_rd(thr_rd_b), .thr_wr(thr_wr_b), .thr_long(thr_long_b), .thr_compr(thr_compr_b),
        .cnt_rd(cnt_rd_b), .cnt_wr(cnt_wr_b), .cnt_long(cnt_long_b), .cnt_compr(cnt_compr_b),
        .cnt_ireq(cnt_ireq_b), .cnt_cycles(cnt_cycles_b),
        .state(st_b), .goal_met(gm_b), .timed_out(to_b)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: state 0..3 and counters rd,wr,long,compr,ireq,cycles as plain integers.
    int m_st[2];
    int m_c[2][6];
    logic [31:0] obs[9];
    logic [31:0] expv[9];
    string nm[9];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            for (int j = 0; j < 6; j++) m_c[i][j] = 0;
        end
    endtask

    task automatic model_step(input int i);
        int nret, maxv, tmo;
        int ev[6];
        int thr[4];
        logic v, t;
        logic [31:0] ins;
        logic [3:0] rm, wm;
        bit goal, hit;
        nret = (i == 0) ? 1 : 2;
        maxv = (i == 0) ? 255 : 15;
        tmo  = 20;
        for (int j = 0; j < 6; j++) ev[j] = 0;
        for (int k = 0; k < nret; k++) begin
            if (i == 0) begin
                v = va; t = ta; ins = insn_a; rm = rm_a; wm = wm_a;
            end else begin
                v = vb[k]; t = trb[k]; ins = insn_b[32*k +: 32]; rm = rm_b[4*k +: 4]; wm = wm_b[4*k +: 4];
            end
            if (v && !t) begin
                if (rm != 4'd0) ev[0]++;
                if (wm != 4'd0) ev[1]++;
                if (ins[1:0] == 2'b11) ev[2]++;
                else ev[3]++;
            end
        end
        ev[4] = (ireq_v && ireq_r) ? 1 : 0;
        ev[5] = 1;
        if (i == 0) begin
            thr[0] = thr_rd_a; thr[1] = thr_wr_a; thr[2] = thr_long_a; thr[3] = thr_compr_a;
        end else begin
            thr[0] = thr_rd_b; thr[1] = thr_wr_b; thr[2] = thr_long_b; thr[3] = thr_compr_b;
        end
        if (!resetn || clear) begin
            m_st[i] = 0;
            for (int j = 0; j < 6; j++) m_c[i][j] = 0;
        end else if (m_st[i] == 0) begin
            if (arm) m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            goal = 1'b1;
            for (int j = 0; j < 4; j++) if (m_c[i][j] < thr[j]) goal = 1'b0;
            hit = (tmo != 0) && (m_c[i][5] >= tmo);
            for (int j = 0; j < 6; j++)
                m_c[i][j] = (m_c[i][j] + ev[j] > maxv) ? maxv : m_c[i][j] + ev[j];
            if (goal) m_st[i] = 2;
            else if (hit) m_st[i] = 3;
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int i);
        if (i == 0) begin
            obs[0] = 32'(cnt_rd_a); obs[1] = 32'(cnt_wr_a); obs[2] = 32'(cnt_long_a);
            obs[3] = 32'(cnt_compr_a); obs[4] = 32'(cnt_ireq_a); obs[5] = 32'(cnt_cycles_a);
            obs[6] = 32'(st_a); obs[7] = 32'(gm_a); obs[8] = 32'(to_a);
        end else begin
            obs[0] = 32'(cnt_rd_b); obs[1] = 32'(cnt_wr_b); obs[2] = 32'(cnt_long_b);
            obs[3] = 32'(cnt_compr_b); obs[4] = 32'(cnt_ireq_b); obs[5] = 32'(cnt_cycles_b);
            obs[6] = 32'(st_b); obs[7] = 32'(gm_b); obs[8] = 32'(to_b);
        end
        for (int j = 0; j < 6; j++) expv[j] = 32'(m_c[i][j]);
        expv[6] = 32'(m_st[i]);
        expv[7] = (m_st[i] == 2) ? 32'd1 : 32'd0;
        expv[8] = (m_st[i] == 3) ? 32'd1 : 32'd0;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; arm = 1'b0; ireq_v = 1'b0; ireq_r = 1'b0;
        va = 1'b0; ta = 1'b0; insn_a = 32'd0; rm_a = 4'd0; wm_a = 4'd0;
        vb = 2'b00; trb = 2'b00; insn_b = 64'd0; rm_b = 8'd0; wm_b = 8'd0;
    endtask

    task automatic clear_and_arm();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            sample(i);
            for (int j = 0; j < 9; j++) begin
                n_checks++;
                if (obs[j] !== 32'd0) $display("FAIL reset_%s[%0d]: got %0d expected 0", nm[j], i, obs[j]);
                else n_pass++;
            end
        end
        resetn = 1'b1;
        tick();
        n_checks++;
        if (st_a !== 2'd0) $display("FAIL reset_release_idle: got %0d expected 0", st_a); else n_pass++;
    endtask

    task automatic test_lw_sw_goal();
        thr_rd_a = 8'd1; thr_wr_a = 8'd1; thr_long_a = 8'd1; thr_compr_a = 8'd0;
        clear_and_arm();
        n_checks++;
        if (st_a !== 2'd1) $display("FAIL arm_state: got %0d expected 1", st_a); else n_pass++;
        va = 1'b1; insn_a = 32'h0000_A083; rm_a = 4'hF;
        tick();
        va = 1'b1; insn_a = 32'h0010_A023; rm_a = 4'h0; wm_a = 4'hF;
        tick();
        idle_inputs();
        n_checks++;
        if ({cnt_rd_a, cnt_wr_a, cnt_long_a} !== {8'd1, 8'd1, 8'd2})
            $display("FAIL lw_sw_counts: got rd=%0d wr=%0d long=%0d expected 1/1/2", cnt_rd_a, cnt_wr_a, cnt_long_a);
        else n_pass++;
        n_checks++;
        if (gm_a !== 1'b0) $display("FAIL lw_sw_goal_early: got %0d expected 0", gm_a); else n_pass++;
        tick();
        n_checks++;
        if (gm_a !== 1'b1 || st_a !== 2'd2) $display("FAIL lw_sw_goal: got gm=%0d st=%0d expected 1/2", gm_a, st_a);
        else n_pass++;
    endtask

    task automatic test_saturation();
        thr_rd_b = 4'd15; thr_wr_b = 4'd15; thr_long_b = 4'd15; thr_compr_b = 4'd15;
        clear_and_arm();
        for (int n = 1; n <= 8; n++) begin
            vb = 2'b11; insn_b = {32'h0000_A083, 32'h0000_A103}; rm_b = 8'hFF;
            tick();
            n_checks++;
            if (int'(cnt_rd_b) != ((2*n > 15) ? 15 : 2*n) || $isunknown(cnt_rd_b))
                $display("FAIL sat_rd_cycle%0d: got %0d expected %0d", n, cnt_rd_b, (2*n > 15) ? 15 : 2*n);
            else n_pass++;
        end
        idle_inputs();
        tick();
        n_checks++;
        if (cnt_rd_b !== 4'd15 || cnt_long_b !== 4'd15 || st_b !== 2'd1)
            $display("FAIL sat_hold: got rd=%0d long=%0d st=%0d expected 15/15/1", cnt_rd_b, cnt_long_b, st_b);
        else n_pass++;
    endtask

    task automatic test_timeout();
        thr_rd_a = 8'd1; thr_wr_a = 8'd0; thr_long_a = 8'd0; thr_compr_a = 8'd0;
        clear_and_arm();
        repeat (20) tick();
        n_checks++;
        if (cnt_cycles_a !== 8'd20 || st_a !== 2'd1)
            $display("FAIL tmo_pre: got cycles=%0d st=%0d expected 20/1", cnt_cycles_a, st_a);
        else n_pass++;
        tick();
        n_checks++;
        if (st_a !== 2'd3 || to_a !== 1'b1 || gm_a !== 1'b0)
            $display("FAIL tmo_fire: got st=%0d to=%0d gm=%0d expected 3/1/0", st_a, to_a, gm_a);
        else n_pass++;
        arm = 1'b1;
        va = 1'b1; insn_a = 32'h0000_A083; rm_a = 4'hF;
        repeat (3) tick();
        idle_inputs();
        n_checks++;
        if (st_a !== 2'd3 || cnt_rd_a !== 8'd0)
            $display("FAIL tmo_sticky: got st=%0d rd=%0d expected 3/0", st_a, cnt_rd_a);
        else n_pass++;
    endtask

    task automatic test_met_beats_timeout();
        thr_rd_a = 8'd1; thr_wr_a = 8'd0; thr_long_a = 8'd0; thr_compr_a = 8'd0;
        clear_and_arm();
        repeat (19) tick();
        va = 1'b1; insn_a = 32'h0000_A083; rm_a = 4'hF;
        tick();
        idle_inputs();
        n_checks++;
        if (cnt_cycles_a !== 8'd20 || cnt_rd_a !== 8'd1 || st_a !== 2'd1)
            $display("FAIL tie_pre: got cycles=%0d rd=%0d st=%0d expected 20/1/1", cnt_cycles_a, cnt_rd_a, st_a);
        else n_pass++;
        tick();
        n_checks++;
        if (st_a !== 2'd2 || to_a !== 1'b0 || gm_a !== 1'b1)
            $display("FAIL tie_met: got st=%0d to=%0d gm=%0d expected 2/0/1", st_a, to_a, gm_a);
        else n_pass++;
    endtask

    task automatic test_trap();
        thr_rd_a = 8'hFF; thr_wr_a = 8'hFF; thr_long_a = 8'hFF; thr_compr_a = 8'hFF;
        clear_and_arm();
        va = 1'b1; ta = 1'b1; insn_a = 32'h0000_A083; rm_a = 4'hF; wm_a = 4'hF;
        tick();
        idle_inputs();
        n_checks++;
        if ({cnt_rd_a, cnt_wr_a, cnt_long_a, cnt_compr_a} !== 32'd0 || cnt_cycles_a !== 8'd1)
            $display("FAIL trap_ignored: got rd=%0d wr=%0d long=%0d compr=%0d cyc=%0d expected 0/0/0/0/1",
                     cnt_rd_a, cnt_wr_a, cnt_long_a, cnt_compr_a, cnt_cycles_a);
        else n_pass++;
    endtask

    task automatic test_clear_arm();
        thr_rd_a = 8'd0; thr_wr_a = 8'd0; thr_long_a = 8'd0; thr_compr_a = 8'd0;
        clear_and_arm();
        tick();
        n_checks++;
        if (st_a !== 2'd2 || cnt_cycles_a !== 8'd1)
            $display("FAIL zero_thr_met: got st=%0d cyc=%0d expected 2/1", st_a, cnt_cycles_a);
        else n_pass++;
        clear = 1'b1; arm = 1'b1;
        tick();
        n_checks++;
        if (st_a !== 2'd0 || cnt_cycles_a !== 8'd0 || gm_a !== 1'b0)
            $display("FAIL clear_arm_idle: got st=%0d cyc=%0d gm=%0d expected 0/0/0", st_a, cnt_cycles_a, gm_a);
        else n_pass++;
        clear = 1'b0;
        tick();
        arm = 1'b0;
        n_checks++;
        if (st_a !== 2'd1) $display("FAIL rearm: got %0d expected 1", st_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        thr_rd_a = 8'hFF; thr_wr_a = 8'hFF; thr_long_a = 8'hFF; thr_compr_a = 8'hFF;
        clear_and_arm();
        va = 1'b1; insn_a = 32'h0000_A083; rm_a = 4'hF;
        repeat (3) tick();
        idle_inputs();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (st_a !== 2'd0 || cnt_rd_a !== 8'd0 || cnt_cycles_a !== 8'd0)
            $display("FAIL async_reset: got st=%0d rd=%0d cyc=%0d expected 0/0/0", st_a, cnt_rd_a, cnt_cycles_a);
        else n_pass++;
        tick();
        resetn = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (st_a !== 2'd0 || st_b !== 2'd0) $display("FAIL reset_wait_arm: got %0d/%0d expected 0/0", st_a, st_b);
        else n_pass++;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 600; n++) begin
            clear  = (n == 0) || ($urandom_range(0, 24) == 0);
            if (clear) begin
                thr_rd_a = 8'($urandom_range(0, 6)); thr_wr_a = 8'($urandom_range(0, 6));
                thr_long_a = 8'($urandom_range(0, 6)); thr_compr_a = 8'($urandom_range(0, 6));
                thr_rd_b = 4'($urandom_range(0, 15)); thr_wr_b = 4'($urandom_range(0, 10));
                thr_long_b = 4'($urandom_range(0, 10)); thr_compr_b = 4'($urandom_range(0, 10));
            end
            arm    = ($urandom_range(0, 2) == 0);
            ireq_v = 1'($urandom); ireq_r = 1'($urandom);
            va     = ($urandom_range(0, 3) != 0);
            ta     = ($urandom_range(0, 3) == 0);
            insn_a = $urandom;
            rm_a   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            wm_a   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
            vb     = 2'($urandom) | 2'($urandom);
            trb    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            insn_b = {$urandom, $urandom};
            rm_b   = 8'($urandom) & 8'($urandom);
            wm_b   = 8'($urandom) & 8'($urandom);
            tick();
            for (int i = 0; i < 2; i++) begin
                sample(i);
                for (int j = 0; j < 9; j++) begin
                    n_checks++;
                    if (obs[j] !== expv[j])
                        $display("FAIL rand_%s[%0d] cycle %0d: got %0d expected %0d", nm[j], i, n, obs[j], expv[j]);
                    else n_pass++;
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        nm = '{"cnt_rd", "cnt_wr", "cnt_long", "cnt_compr", "cnt_ireq", "cnt_cycles", "state", "goal_met", "timed_out"};
        thr_rd_a = 8'd0; thr_wr_a = 8'd0; thr_long_a = 8'd0; thr_compr_a = 8'd0;
        thr_rd_b = 4'd0; thr_wr_b = 4'd0; thr_long_b = 4'd0; thr_compr_b = 4'd0;
        test_reset();
        test_lw_sw_goal();
        test_saturation();
        test_timeout();
        test_met_beats_timeout();
        test_trap();
        test_clear_arm();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
